// File: rtl/ahb_regfile_slave.sv
// AHB-Lite slave fronting a bank of 32-bit registers with programmable wait states and byte strobes.
// Optional feature macro: AHB_ERR_RESP_EN (two-cycle ERROR response for unmapped transfers).
module ahb_regfile_slave #(
   parameter int NUM_REGS    = 4,
   parameter int WAIT_CYCLES = 0
) (
   input  logic                   HCLK,
   input  logic                   HRESETn,
   input  logic                   HSEL,
   input  logic [31:0]            HADDR,
   input  logic [1:0]             HTRANS,
   input  logic                   HWRITE,
   input  logic [2:0]             HSIZE,
   input  logic [31:0]            HWDATA,
   input  logic                   HREADY,
   output logic [31:0]            HRDATA,
   output logic                   HREADYOUT,
   output logic                   HRESP,
   output logic [32*NUM_REGS-1:0] regs_o
);

`ifdef AHB_ERR_RESP_EN
   typedef enum logic [2:0] {S_IDLE, S_WAIT, S_DONE, S_ERR1, S_ERR2} state_t;
`else
   typedef enum logic [2:0] {S_IDLE, S_WAIT, S_DONE} state_t;
`endif

   state_t      r_state;
   logic [2:0]  r_cnt;
   logic [5:0]  r_addr;
   logic [2:0]  r_size;
   logic        r_write;
   logic        r_unmap;
   logic        r_hreadyout;
   logic [31:0] r_regs [NUM_REGS];
`ifdef AHB_ERR_RESP_EN
   logic        r_hresp;
`endif

   logic        w_accept;
   logic        w_unmapped;
   logic        w_commit;
   logic [3:0]  w_strobe;
   logic [31:0] w_rdata;
   logic        w_unused;

   function automatic logic f_unmapped(input logic [5:0] addr, input logic [2:0] size);
      logic bad;
      bad = ({28'd0, addr[5:2]} >= 32'(NUM_REGS));
      case (size)
         3'd0:    bad = bad;
         3'd1:    bad = bad | addr[0];
         3'd2:    bad = bad | (|addr[1:0]);
         default: bad = 1'b1;
      endcase
      return bad;
   endfunction

   function automatic logic [3:0] f_strobe(input logic [1:0] lane, input logic [2:0] size);
      logic [3:0] strb;
      case (size)
         3'd0:    strb = 4'b0001 << lane;
         3'd1:    strb = lane[1] ? 4'b1100 : 4'b0011;
         default: strb = 4'b1111;
      endcase
      return strb;
   endfunction

   assign w_accept   = HSEL & HTRANS[1] & HREADY;
   assign w_unmapped = f_unmapped(HADDR[5:0], HSIZE);
   assign w_unused   = &{1'b0, HADDR[31:6], HTRANS[0]};

   // IDLE, DONE and ERR2 all behave as "ready for a new address phase".
   always_ff @(posedge HCLK or negedge HRESETn) begin
      if (!HRESETn) begin
         r_state     <= S_IDLE;
         r_cnt       <= '0;
         r_addr      <= '0;
         r_size      <= '0;
         r_write     <= 1'b0;
         r_unmap     <= 1'b0;
         r_hreadyout <= 1'b1;
`ifdef AHB_ERR_RESP_EN
         r_hresp     <= 1'b0;
`endif
      end else begin
         case (r_state)
            S_WAIT: begin
               if (r_cnt == 3'd0) begin
                  r_state     <= S_DONE;
                  r_hreadyout <= 1'b1;
               end else begin
                  r_cnt <= r_cnt - 3'd1;
               end
            end
`ifdef AHB_ERR_RESP_EN
            S_ERR1: begin
               r_state     <= S_ERR2;
               r_hreadyout <= 1'b1;
               r_hresp     <= 1'b1;
            end
`endif
            default: begin
               r_hreadyout <= 1'b1;
`ifdef AHB_ERR_RESP_EN
               r_hresp     <= 1'b0;
`endif
               if (w_accept) begin
                  r_addr  <= HADDR[5:0];
                  r_size  <= HSIZE;
                  r_write <= HWRITE;
                  r_unmap <= w_unmapped;
`ifdef AHB_ERR_RESP_EN
                  if (w_unmapped) begin
                     r_state     <= S_ERR1;
                     r_hreadyout <= 1'b0;
                     r_hresp     <= 1'b1;
                  end else
`endif
                  if (WAIT_CYCLES > 0) begin
                     r_state     <= S_WAIT;
                     r_cnt       <= 3'(WAIT_CYCLES - 1);
                     r_hreadyout <= 1'b0;
                  end else begin
                     r_state <= S_DONE;
                  end
               end else begin
                  r_state <= S_IDLE;
               end
            end
         endcase
      end
   end

   assign w_commit = (r_state == S_DONE) && r_write && !r_unmap;
   assign w_strobe = f_strobe(r_addr[1:0], r_size);

   // HWDATA is sampled on the edge that ends DONE; lanes outside the strobe hold.
   always_ff @(posedge HCLK or negedge HRESETn) begin
      if (!HRESETn) begin
         for (int i = 0; i < NUM_REGS; i++) r_regs[i] <= '0;
      end else if (w_commit) begin
         for (int i = 0; i < NUM_REGS; i++) begin
            if (r_addr[5:2] == 4'(i)) begin
               for (int b = 0; b < 4; b++) begin
                  if (w_strobe[b]) r_regs[i][8*b +: 8] <= HWDATA[8*b +: 8];
               end
            end
         end
      end
   end

   always_comb begin
      w_rdata = '0;
      if ((r_state == S_DONE) && !r_write && !r_unmap) begin
         for (int i = 0; i < NUM_REGS; i++) begin
            if (r_addr[5:2] == 4'(i)) w_rdata = r_regs[i];
         end
      end
   end

   for (genvar g = 0; g < NUM_REGS; g++) begin : g_regs
      assign regs_o[32*g +: 32] = r_regs[g];
   end

   assign HRDATA    = w_rdata;
   assign HREADYOUT = r_hreadyout;
`ifdef AHB_ERR_RESP_EN
   assign HRESP     = r_hresp;
`else
   assign HRESP     = 1'b0;
`endif

endmodule

// File: tb/tb_ahb_regfile_slave.sv
// Self-checking bench: two slaves (no wait / 3 wait states) checked against a byte-lane register model.
module tb_ahb_regfile_slave;

   localparam int NR0 = 4;
   localparam int NR1 = 8;
   localparam int W0  = 0;
   localparam int W1  = 3;
`ifdef AHB_ERR_RESP_EN
   localparam bit ERR_EN = 1'b1;
`else
   localparam bit ERR_EN = 1'b0;
`endif

   logic clock  = 1'b0;
   logic resetN = 1'b0;
   logic hsel0 = 1'b0, hsel1 = 1'b0;
   logic [31:0] haddr = '0, hwdata = '0;
   logic [1:0]  htrans = 2'b00;
   logic        hwrite = 1'b0;
   logic [2:0]  hsize = 3'd0;
   logic [31:0] hrdata0, hrdata1;
   logic        ro0, ro1, resp0, resp1;
   logic [32*NR0-1:0] regs0;
   logic [32*NR1-1:0] regs1;

   logic [31:0] mregs [2][16];
   int errors = 0;
   int checks = 0;

   always #5 clock = ~clock;

   ahb_regfile_slave #(.NUM_REGS(NR0), .WAIT_CYCLES(W0)) dut0 (
      .HCLK(clock), .HRESETn(resetN), .HSEL(hsel0), .HADDR(haddr), .HTRANS(htrans),
      .HWRITE(hwrite), .HSIZE(hsize), .HWDATA(hwdata), .HREADY(ro0),
      .HRDATA(hrdata0), .HREADYOUT(ro0), .HRESP(resp0), .regs_o(regs0));

   ahb_regfile_slave #(.NUM_REGS(NR1), .WAIT_CYCLES(W1)) dut1 (
      .HCLK(clock), .HRESETn(resetN), .HSEL(hsel1), .HADDR(haddr), .HTRANS(htrans),
      .HWRITE(hwrite), .HSIZE(hsize), .HWDATA(hwdata), .HREADY(ro1),
      .HRDATA(hrdata1), .HREADYOUT(ro1), .HRESP(resp1), .regs_o(regs1));

   function automatic int nregs(input int s);
      return (s != 0) ? NR1 : NR0;
   endfunction

   function automatic int nwait(input int s);
      return (s != 0) ? W1 : W0;
   endfunction

   function automatic logic rdy(input int s);
      return (s != 0) ? ro1 : ro0;
   endfunction

   function automatic logic respOf(input int s);
      return (s != 0) ? resp1 : resp0;
   endfunction

   function automatic logic [31:0] rdataOf(input int s);
      return (s != 0) ? hrdata1 : hrdata0;
   endfunction

   function automatic logic [31:0] regWord(input int s, input int i);
      return (s != 0) ? regs1[32*i +: 32] : regs0[32*i +: 32];
   endfunction

   function automatic bit isUnmapped(input int s, input logic [5:0] a, input logic [2:0] sz);
      int ai;
      ai = int'(a);
      return (ai / 4 >= nregs(s)) || (sz > 3'd2) || (sz == 3'd1 && ai % 2 != 0) ||
             (sz == 3'd2 && ai % 4 != 0);
   endfunction

   function automatic void modelWrite(input int s, input logic [5:0] a, input logic [2:0] sz,
                                      input logic [31:0] wd);
      int n, lane0, first;
      n     = 1 << int'(sz);
      lane0 = int'(a) % 4;
      first = lane0 - (lane0 % n);
      for (int b = first; b < first + n; b++) mregs[s][int'(a) / 4][8*b +: 8] = wd[8*b +: 8];
   endfunction

   function automatic void modelClear();
      for (int s = 0; s < 2; s++)
         for (int i = 0; i < 16; i++) mregs[s][i] = '0;
   endfunction

   function automatic int expLow(input int s, input bit um);
      return (um && ERR_EN) ? 1 : nwait(s);
   endfunction

   function automatic logic [31:0] expRdata(input int s, input logic [5:0] a, input bit wr, input bit um);
      return (wr || um) ? 32'h0 : mregs[s][int'(a) / 4];
   endfunction

   task automatic idle(input int n);
      for (int k = 0; k < n; k++) begin
         @(negedge clock);
         hsel0 = 1'b0; hsel1 = 1'b0; htrans = 2'b00;
      end
   endtask

   // One complete transfer; returns what was observed during its data phase.
   task automatic xfer(input int s, input logic [5:0] a, input bit wr, input logic [2:0] sz,
                       input logic [31:0] wd, output int lowC, output bit lowResp,
                       output bit finResp, output logic [31:0] rdata, output bit early);
      logic [31:0] snap [16];
      @(negedge clock);
      if (s != 0) hsel1 = 1'b1; else hsel0 = 1'b1;
      haddr = {26'd0, a}; htrans = 2'b10; hwrite = wr; hsize = sz;
      @(negedge clock);
      hsel0 = 1'b0; hsel1 = 1'b0; htrans = 2'b00; hwdata = wd;
      for (int i = 0; i < nregs(s); i++) snap[i] = regWord(s, i);
      lowC = 0; lowResp = 1'b0; early = 1'b0;
      while (rdy(s) !== 1'b1 && lowC < 20) begin
         lowC++;
         if (respOf(s) === 1'b1) lowResp = 1'b1;
         for (int i = 0; i < nregs(s); i++) if (regWord(s, i) !== snap[i]) early = 1'b1;
         @(negedge clock);
      end
      finResp = respOf(s);
      rdata   = rdataOf(s);
   endtask

   task automatic test_reset();
      modelClear();
      resetN = 1'b0;
      for (int k = 0; k < 4; k++) begin
         @(negedge clock);
         hsel0 = 1'b1; hsel1 = 1'b1; haddr = 32'(4 * k); htrans = 2'b10;
         hwrite = 1'b1; hsize = 3'd2; hwdata = $urandom;
         #1;
         checks++;
         if ({ro0, ro1} !== 2'b11) begin errors++; $display("[TB] FAIL resetReady: got %b need 11", {ro0, ro1}); end
         checks++;
         if ({resp0, resp1} !== 2'b00) begin errors++; $display("[TB] FAIL resetResp: got %b need 00", {resp0, resp1}); end
         checks++;
         if (regs0 !== '0 || regs1 !== '0) begin errors++; $display("[TB] FAIL resetRegs: got %h / %h need 0", regs0, regs1); end
         checks++;
         if (hrdata0 !== 32'h0 || hrdata1 !== 32'h0) begin errors++; $display("[TB] FAIL resetRdata: got %h / %h need 0", hrdata0, hrdata1); end
      end
      @(negedge clock);
      hsel0 = 1'b0; hsel1 = 1'b0; htrans = 2'b00;
      resetN = 1'b1;
      idle(2);
      checks++;
      if (regs0 !== '0 || regs1 !== '0) begin errors++; $display("[TB] FAIL postResetRegs: got %h / %h need 0", regs0, regs1); end
   endtask

   task automatic test_back_to_back();
      @(negedge clock);
      hsel0 = 1'b1; haddr = 32'h04; htrans = 2'b10; hwrite = 1'b1; hsize = 3'd2;
      @(negedge clock);
      hwdata = 32'hDEADBEEF; hwrite = 1'b0; htrans = 2'b10;
      checks++;
      if (ro0 !== 1'b1 || resp0 !== 1'b0) begin errors++; $display("[TB] FAIL b2bWriteDone: ready=%b resp=%b need 1/0", ro0, resp0); end
      modelWrite(0, 6'h04, 3'd2, 32'hDEADBEEF);
      @(negedge clock);
      hsel0 = 1'b0; htrans = 2'b00;
      checks++;
      if (hrdata0 !== 32'hDEADBEEF) begin errors++; $display("[TB] FAIL b2bRead: got %h need deadbeef", hrdata0); end
      checks++;
      if (regs0[63:32] !== 32'hDEADBEEF) begin errors++; $display("[TB] FAIL b2bRegsO: got %h need deadbeef", regs0[63:32]); end
   endtask

   task automatic test_pipelined_random();
      bit pv = 1'b0, pw = 1'b0;
      logic [5:0] pa = '0;
      logic [2:0] ps = '0;
      logic [31:0] pd = '0;
      int idx, szi, off;
      for (int k = 0; k <= 20; k++) begin
         @(negedge clock);
         if (pv) begin
            checks++;
            if (ro0 !== 1'b1) begin errors++; $display("[TB] FAIL pipeReady[%0d]: got %b need 1", k, ro0); end
            if (!pw) begin
               checks++;
               if (hrdata0 !== mregs[0][int'(pa) / 4])
                  begin errors++; $display("[TB] FAIL pipeRead[%0d]: got %h need %h", k, hrdata0, mregs[0][int'(pa) / 4]); end
            end else begin
               modelWrite(0, pa, ps, pd);
            end
            hwdata = pd;
         end
         if (k < 20) begin
            idx = $urandom_range(NR0 - 1, 0);
            szi = $urandom_range(2, 0);
            off = (szi == 0) ? $urandom_range(3, 0) : (szi == 1) ? 2 * $urandom_range(1, 0) : 0;
            pa = 6'(idx * 4 + off); ps = 3'(szi); pw = $urandom_range(1, 0) != 0; pd = $urandom; pv = 1'b1;
            hsel0 = 1'b1; haddr = {26'd0, pa}; htrans = (k == 0) ? 2'b10 : 2'b11; hwrite = pw; hsize = ps;
         end else begin
            hsel0 = 1'b0; htrans = 2'b00; pv = 1'b0;
         end
      end
      idle(1);
      for (int i = 0; i < NR0; i++) begin
         checks++;
         if (regWord(0, i) !== mregs[0][i]) begin errors++; $display("[TB] FAIL pipeRegs[%0d]: got %h need %h", i, regWord(0, i), mregs[0][i]); end
      end
   endtask

   task automatic test_byte_lanes();
      int lowC; bit lr, fr, early; logic [31:0] rd;
      xfer(0, 6'h08, 1'b1, 3'd2, 32'h11223344, lowC, lr, fr, rd, early);
      modelWrite(0, 6'h08, 3'd2, 32'h11223344);
      xfer(0, 6'h09, 1'b1, 3'd0, 32'h0000AA00, lowC, lr, fr, rd, early);
      modelWrite(0, 6'h09, 3'd0, 32'h0000AA00);
      idle(1);
      checks++;
      if (regs0[95:64] !== 32'h1122AA44) begin errors++; $display("[TB] FAIL byteLane: got %h need 1122aa44", regs0[95:64]); end
      xfer(0, 6'h0A, 1'b1, 3'd1, 32'hBEEF0000, lowC, lr, fr, rd, early);
      modelWrite(0, 6'h0A, 3'd1, 32'hBEEF0000);
      idle(1);
      checks++;
      if (regs0[95:64] !== 32'hBEEFAA44) begin errors++; $display("[TB] FAIL halfLane: got %h need beefaa44", regs0[95:64]); end
      xfer(0, 6'h08, 1'b0, 3'd2, 32'h0, lowC, lr, fr, rd, early);
      checks++;
      if (rd !== 32'hBEEFAA44) begin errors++; $display("[TB] FAIL laneReadback: got %h need beefaa44", rd); end
      checks++;
      if (lowC !== 0 || fr !== 1'b0) begin errors++; $display("[TB] FAIL noWaitRead: low=%0d resp=%b need 0/0", lowC, fr); end
   endtask

   task automatic test_wait_states();
      int lowC; bit lr, fr, early, um, wr; logic [31:0] rd, wd; logic [5:0] a; logic [2:0] sz;
      xfer(1, 6'h00, 1'b1, 3'd2, 32'hA5A50F0F, lowC, lr, fr, rd, early);
      checks++;
      if (lowC !== W1) begin errors++; $display("[TB] FAIL waitWrite: low=%0d need %0d", lowC, W1); end
      checks++;
      if (early !== 1'b0) begin errors++; $display("[TB] FAIL earlyCommit: got %b need 0", early); end
      modelWrite(1, 6'h00, 3'd2, 32'hA5A50F0F);
      xfer(1, 6'h00, 1'b0, 3'd2, 32'h0, lowC, lr, fr, rd, early);
      checks++;
      if (lowC !== W1) begin errors++; $display("[TB] FAIL waitRead: low=%0d need %0d", lowC, W1); end
      checks++;
      if (rd !== 32'hA5A50F0F) begin errors++; $display("[TB] FAIL waitRdata: got %h need a5a50f0f", rd); end
      for (int k = 0; k < 30; k++) begin
         a  = 6'($urandom_range(63, 0));
         sz = ($urandom_range(9, 0) == 0) ? 3'($urandom_range(7, 3)) : 3'($urandom_range(2, 0));
         wr = $urandom_range(1, 0) != 0;
         wd = $urandom;
         um = isUnmapped(1, a, sz);
         xfer(1, a, wr, sz, wd, lowC, lr, fr, rd, early);
         checks++;
         if (lowC !== expLow(1, um)) begin errors++; $display("[TB] FAIL rndLow[%0d]: got %0d need %0d", k, lowC, expLow(1, um)); end
         checks++;
         if (lr !== (um && ERR_EN) || fr !== (um && ERR_EN))
            begin errors++; $display("[TB] FAIL rndResp[%0d]: got %b%b need %b", k, lr, fr, um && ERR_EN); end
         checks++;
         if (rd !== expRdata(1, a, wr, um)) begin errors++; $display("[TB] FAIL rndRdata[%0d]: got %h need %h", k, rd, expRdata(1, a, wr, um)); end
         checks++;
         if (early !== 1'b0) begin errors++; $display("[TB] FAIL rndEarly[%0d]: got %b need 0", k, early); end
         if (wr && !um) modelWrite(1, a, sz, wd);
      end
      idle(1);
      for (int i = 0; i < NR1; i++) begin
         checks++;
         if (regWord(1, i) !== mregs[1][i]) begin errors++; $display("[TB] FAIL rndRegs[%0d]: got %h need %h", i, regWord(1, i), mregs[1][i]); end
      end
   endtask

   task automatic test_unmapped();
      int lowC; bit lr, fr, early, um;
      logic [31:0] rd;
      logic [5:0]  ta [4] = '{6'h10, 6'h05, 6'h10, 6'h00};
      logic [2:0]  ts [4] = '{3'd2, 3'd1, 3'd2, 3'd3};
      bit          tw [4] = '{1'b1, 1'b1, 1'b0, 1'b0};
      xfer(0, 6'h00, 1'b1, 3'd2, 32'h5555AAAA, lowC, lr, fr, rd, early);
      modelWrite(0, 6'h00, 3'd2, 32'h5555AAAA);
      for (int k = 0; k < 4; k++) begin
         um = isUnmapped(0, ta[k], ts[k]);
         xfer(0, ta[k], tw[k], ts[k], 32'hCAFEF00D, lowC, lr, fr, rd, early);
         checks++;
         if (lowC !== expLow(0, um)) begin errors++; $display("[TB] FAIL umLow[%0d]: got %0d need %0d", k, lowC, expLow(0, um)); end
         checks++;
         if (lr !== (um && ERR_EN) || fr !== (um && ERR_EN))
            begin errors++; $display("[TB] FAIL umResp[%0d]: got %b%b need %b", k, lr, fr, um && ERR_EN); end
         checks++;
         if (rd !== 32'h0) begin errors++; $display("[TB] FAIL umRdata[%0d]: got %h need 0", k, rd); end
      end
      idle(1);
      for (int i = 0; i < NR0; i++) begin
         checks++;
         if (regWord(0, i) !== mregs[0][i]) begin errors++; $display("[TB] FAIL umRegs[%0d]: got %h need %h", i, regWord(0, i), mregs[0][i]); end
      end
   endtask

   task automatic test_reset_mid_transfer();
      int lowC; bit lr, fr, early; logic [31:0] rd;
      xfer(1, 6'h04, 1'b1, 3'd2, 32'hFFFF0000, lowC, lr, fr, rd, early);
      @(negedge clock);
      hsel1 = 1'b1; haddr = 32'h0; htrans = 2'b10; hwrite = 1'b1; hsize = 3'd2;
      @(negedge clock);
      hsel1 = 1'b0; htrans = 2'b00; hwdata = 32'h12345678;
      checks++;
      if (ro1 !== 1'b0) begin errors++; $display("[TB] FAIL midWaitReady: got %b need 0", ro1); end
      @(negedge clock);
      #1 resetN = 1'b0;
      #1;
      modelClear();
      checks++;
      if (ro1 !== 1'b1 || resp1 !== 1'b0 || hrdata1 !== 32'h0)
         begin errors++; $display("[TB] FAIL midReset: ready=%b resp=%b rdata=%h need 1/0/0", ro1, resp1, hrdata1); end
      checks++;
      if (regs1 !== '0 || regs0 !== '0) begin errors++; $display("[TB] FAIL midResetRegs: got %h / %h need 0", regs1, regs0); end
      @(negedge clock);
      resetN = 1'b1;
      idle(6);
      checks++;
      if (regs1 !== '0) begin errors++; $display("[TB] FAIL writeLost: got %h need 0", regs1); end
      xfer(1, 6'h00, 1'b0, 3'd2, 32'h0, lowC, lr, fr, rd, early);
      checks++;
      if (rd !== 32'h0 || lowC !== W1) begin errors++; $display("[TB] FAIL postResetRead: rdata=%h low=%0d need 0/%0d", rd, lowC, W1); end
   endtask

   initial begin
      #500000;
      $display("[TB] FAIL watchdog: simulation did not finish, errors=%0d", errors);
      $fatal(1, "[TB] timeout");
   end

   initial begin
      test_reset();
      test_back_to_back();
      test_pipelined_random();
      test_byte_lanes();
      test_wait_states();
      test_unmapped();
      test_reset_mid_transfer();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/ahb_regfile_slave.md
# ahb_regfile_slave

AHB-Lite slave with a bank of 32-bit software-visible registers, placed on the SoC bus as the responder to the bus master. It accepts single and back-to-back transfers, inserts a programmable number of wait states per data phase, applies byte/halfword/word write strobes, and exports every register as a flat vector to the SoC datapath. It owns the bus-slave side of the register interface that the SoC presents on its `registers` output.

## Interface
Parameters:
- NUM_REGS, 4, number of 32-bit registers (1..16); register i at byte offset 4*i
- WAIT_CYCLES, 0, wait states inserted in every data phase (0..7)

Ports:
- HCLK  in  1  bus clock; all state updates on rising edge
- HRESETn  in  1  reset, asynchronous assert, active-low
- HSEL  in  1  slave select from decoder
- HADDR  in  32  address; only bits [5:0] decoded
- HTRANS  in  2  transfer type; NONSEQ=2'b10, SEQ=2'b11 start a transfer, IDLE/BUSY ignored
- HWRITE  in  1  1 = write
- HSIZE  in  3  0 = byte, 1 = halfword, 2 = word; others treated as unmapped
- HWDATA  in  32  write data, valid in data phase
- HREADY  in  1  bus-level ready (previous transfer completing)
- HRDATA  out  32  read data, valid when HREADYOUT=1 in a read data phase
- HREADYOUT  out  1  slave ready
- HRESP  out  1  0 = OKAY, 1 = ERROR
- regs_o  out  32*NUM_REGS  register contents, register 0 at bits [31:0]

## Operation
- Address phase accepted on a rising edge when HSEL & HTRANS[1] & HREADY; latch HADDR[5:0], HWRITE, HSIZE into data-phase registers.
- States: IDLE (no data phase pending), WAIT (counting wait states), DONE (HREADYOUT=1 final cycle), ERR1, ERR2.
- IDLE -> WAIT on accept if WAIT_CYCLES>0, else -> DONE. WAIT counts WAIT_CYCLES cycles with HREADYOUT=0, then -> DONE.
- DONE: HREADYOUT=1; if a new transfer is accepted in the same cycle, next state as from IDLE, else -> IDLE.
- Write commits on the rising edge ending DONE. Byte lanes: byte writes lane HADDR[1:0]; halfword writes lanes {HADDR[1],0}+0..1; word writes all lanes. Unwritten lanes keep their value.
- Read: HRDATA = register[HADDR[5:2]] combinationally from current register state during DONE; 0 in all other cycles.
- Unmapped = index >= NUM_REGS, HSIZE>2, or misaligned (halfword with HADDR[0]=1, word with HADDR[1:0]!=0). Handling per Configuration.
- Back-to-back write then read to same register: read returns newly written value.
- HTRANS IDLE/BUSY or HSEL=0 in address phase: no data phase, HREADYOUT stays 1, HRESP=0.

## Timing
- Reset (async): state IDLE, counter 0, HREADYOUT=1, HRESP=0, HRDATA=0, all registers and regs_o=0. Reset mid-transfer aborts it; pending write is discarded.
- Latency: data phase lasts WAIT_CYCLES+1 cycles for OKAY transfers; regs_o updates the cycle after the write's DONE edge.
- Pipelined transfers: address phase of transfer N+1 overlaps DONE of transfer N; full throughput one transfer/cycle at WAIT_CYCLES=0.
- HREADYOUT never low outside WAIT/ERR1.

## Configuration
- AHB_ERR_RESP_EN defined: unmapped transfer -> ERR1 (HREADYOUT=0, HRESP=1) then ERR2 (HREADYOUT=1, HRESP=1) -> IDLE; no wait states, no write, HRDATA=0. An address phase presented during ERR2 is accepted normally.
- Not defined: unmapped transfers complete as OKAY with normal wait states; writes ignored, reads return 0; HRESP tied 0, ERR states absent.

## Test plan
- Reset: hold HRESETn=0, drive NONSEQ writes -> HREADYOUT=1, HRESP=0, regs_o all 0, no register change.
- WAIT_CYCLES=0: word write 0xDEADBEEF to 0x04, then read 0x04 back-to-back -> regs_o[63:32]=0xDEADBEEF, HRDATA=0xDEADBEEF one cycle after read address phase.
- Byte write 0xAA to 0x09 over register 2 = 0x11223344 -> register 2 = 0x1122AA44; halfword 0xBEEF to 0x0A -> 0xBEEFAA44.
- WAIT_CYCLES=3: word read of 0x00 -> HREADYOUT low exactly 3 cycles, then high with correct HRDATA; write commits only at final edge.
- With AHB_ERR_RESP_EN: word write to 0x10 (NUM_REGS=4) -> HRESP=1 for two cycles, HREADYOUT 0 then 1, registers unchanged; without macro -> OKAY, read returns 0.
- Assert HRESETn low during WAIT of a write -> outputs return to reset values immediately, write lost.
